// File: rtl/aoi_fall_monitor.sv
// Synchronizes and debounces the asynchronous AOI gate output f.
// Produces a clean level, one-cycle fall/rise strobes and a saturating fall counter.
module aoi_fall_monitor #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f,
  input  logic             clr_cnt,
  output logic             f_clean,
  output logic             fall_pulse,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             cnt_sat
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_HIGH,
    ST_FALLING,
    ST_LOW,
    ST_RISING
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2;
  logic [DEB_W-1:0] deb_cnt, deb_nxt;
  logic             f_clean_nxt;
  logic             fall_nxt, rise_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  // Two-flop synchronizer; reset value matches the idle level of the gate.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= f;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HIGH;
      deb_cnt    <= '0;
      f_clean    <= 1'b1;
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
      fall_cnt   <= '0;
      cnt_sat    <= 1'b0;
    end else begin
      state      <= state_nxt;
      deb_cnt    <= deb_nxt;
      f_clean    <= f_clean_nxt;
      fall_pulse <= fall_nxt;
      rise_pulse <= rise_nxt;
      fall_cnt   <= cnt_nxt;
      cnt_sat    <= sat_nxt;
    end
  end

  // deb_cnt counts opposite-level samples already seen; acceptance happens on
  // the sample that brings the run to DEB_CYCLES.
  always_comb begin
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    f_clean_nxt = f_clean;
    fall_nxt    = 1'b0;
    rise_nxt    = 1'b0;
    case (state)
      ST_HIGH: begin
        if (!s2) begin
          if (DEB_CYCLES == 1) begin
            state_nxt   = ST_LOW;
            deb_nxt     = '0;
            f_clean_nxt = 1'b0;
            fall_nxt    = 1'b1;
          end else begin
            state_nxt = ST_FALLING;
            deb_nxt   = DEB_ONE;
          end
        end
      end
      ST_FALLING: begin
        if (s2) begin
          state_nxt = ST_HIGH;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = ST_LOW;
          deb_nxt     = '0;
          f_clean_nxt = 1'b0;
          fall_nxt    = 1'b1;
        end else begin
          deb_nxt = deb_cnt + DEB_ONE;
        end
      end
      ST_LOW: begin
        if (s2) begin
          if (DEB_CYCLES == 1) begin
            state_nxt   = ST_HIGH;
            deb_nxt     = '0;
            f_clean_nxt = 1'b1;
            rise_nxt    = 1'b1;
          end else begin
            state_nxt = ST_RISING;
            deb_nxt   = DEB_ONE;
          end
        end
      end
      ST_RISING: begin
        if (!s2) begin
          state_nxt = ST_LOW;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = ST_HIGH;
          deb_nxt     = '0;
          f_clean_nxt = 1'b1;
          rise_nxt    = 1'b1;
        end else begin
          deb_nxt = deb_cnt + DEB_ONE;
        end
      end
      default: begin
        state_nxt   = ST_HIGH;
        deb_nxt     = '0;
        f_clean_nxt = 1'b1;
      end
    endcase
  end

  // A clear coinciding with a fall clears first and then counts that fall.
  always_comb begin
    cnt_nxt = fall_cnt;
    sat_nxt = cnt_sat;
    if (fall_nxt) begin
      if (clr_cnt) begin
        cnt_nxt = CNT_ONE;
        sat_nxt = 1'b0;
      end else if (fall_cnt != CNT_MAX) begin
        cnt_nxt = fall_cnt + CNT_ONE;
        sat_nxt = (fall_cnt == (CNT_MAX - CNT_ONE));
      end
    end else if (clr_cnt) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_aoi_fall_monitor.sv
// Randomized and directed bench for aoi_fall_monitor with a queue-based scoreboard
// fed by a run-length reference model of the debouncer.
module tb_aoi_fall_monitor;

  localparam int DEB = 4;
  localparam int CW  = 4;
  localparam int MAXCNT = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          f;
  logic          clr_cnt;
  logic          f_clean;
  logic          fall_pulse;
  logic          rise_pulse;
  logic [CW-1:0] fall_cnt;
  logic          cnt_sat;

  typedef struct packed {
    logic          f_clean;
    logic          fall;
    logic          rise;
    logic [CW-1:0] cnt;
    logic          sat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  aoi_fall_monitor #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .f         (f),
    .clr_cnt   (clr_cnt),
    .f_clean   (f_clean),
    .fall_pulse(fall_pulse),
    .rise_pulse(rise_pulse),
    .fall_cnt  (fall_cnt),
    .cnt_sat   (cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic clrv, input logic rstv, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      f       = fv;
      clr_cnt = clrv;
      reset   = rstv;
    end
  endtask

  // Reference model: the FSM sees f two edges late (1 right after reset); a level
  // change is accepted once the last DEB seen samples all differ from the clean level.
  logic m_s1, m_s2, m_clean, m_fall, m_rise;
  int   m_cnt;
  logic hist[$];

  always @(posedge clk) begin
    bit all_opp;
    exp_t e;
    if (reset) begin
      m_s1 = 1'b1;
      m_s2 = 1'b1;
      hist.delete();
      m_clean = 1'b1;
      m_fall  = 1'b0;
      m_rise  = 1'b0;
      m_cnt   = 0;
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      m_fall = 1'b0;
      m_rise = 1'b0;
      all_opp = (hist.size() == DEB);
      foreach (hist[k]) if (hist[k] == m_clean) all_opp = 0;
      if (all_opp) begin
        if (m_clean) m_fall = 1'b1;
        else         m_rise = 1'b1;
        m_clean = ~m_clean;
      end
      if (m_fall) m_cnt = clr_cnt ? 1 : ((m_cnt < MAXCNT) ? m_cnt + 1 : MAXCNT);
      else if (clr_cnt) m_cnt = 0;
      m_s2 = m_s1;
      m_s1 = f;
    end
    e.f_clean = m_clean;
    e.fall    = m_fall;
    e.rise    = m_rise;
    e.cnt     = CW'(m_cnt);
    e.sat     = (m_cnt == MAXCNT);
    exp_q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("f_clean", f_clean, e.f_clean);
      checkOutput("fall_pulse", fall_pulse, e.fall);
      checkOutput("rise_pulse", rise_pulse, e.rise);
      checkOutput("fall_cnt", fall_cnt, e.cnt);
      checkOutput("cnt_sat", cnt_sat, e.sat);
    end
  end

  initial begin
    f       = 1'b1;
    clr_cnt = 1'b0;
    reset   = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 20);
    checkOutput("idle_cnt", fall_cnt, 0);
    checkOutput("idle_clean", f_clean, 1);

    // Clean fall and rise
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("clean_fall_cnt", fall_cnt, 1);
    checkOutput("clean_fall_level", f_clean, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);

    // Glitch rejection, then minimal-length accepted pulses
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    checkOutput("glitch_cnt", fall_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("glitch_after_cnt", fall_cnt, 1);
    checkOutput("glitch_after_level", f_clean, 1);

    // Saturation over 17 fall/rise pairs
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    for (int p = 0; p < 17; p++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 7);
      applyStimulus(1'b1, 1'b0, 1'b0, 7);
    end
    checkOutput("sat_cnt", fall_cnt, MAXCNT);
    checkOutput("sat_flag", cnt_sat, 1);

    // Clear colliding with a fall, then clear alone
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8);
      applyStimulus(1'b1, 1'b0, 1'b0, 8);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    @(posedge clk);
    #2;
    checkOutput("clr_collide_cnt", fall_cnt, 1);
    checkOutput("clr_collide_sat", cnt_sat, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    @(posedge clk);
    #2;
    checkOutput("clr_alone_cnt", fall_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);

    // Reset in the middle of a debounce
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    checkOutput("reset_mid_level", f_clean, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7);

    // Randomized bursts with occasional clears and resets
    for (int b = 0; b < 200; b++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        applyStimulus(lvl, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0), 1);
      end
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 12);
    @(posedge clk);
    #3;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aoi_fall_monitor.md
Name: aoi_fall_monitor

Overview:
- Downstream consumer of the switch-level AOI gate output f = ~((a&b) | (c&d&e)).
- Brings f into the clock domain through a 2-flop synchronizer and debounces it with a 4-state FSM.
- Emits a clean level, single-cycle fall/rise strobes and a saturating count of debounced falling events.
- Sits between the transistor-level gate and the synchronous control logic that reacts to the gate asserting (f going low).

Parameters:
- DEB_CYCLES, 4, consecutive synchronized samples required to accept a level change; legal range 1 to 255.
- CNT_W, 8, width of the falling-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- f  input  1  asynchronous AOI gate output; idle value 1.
- clr_cnt  input  1  synchronous clear of fall_cnt and cnt_sat.
- f_clean  output  1  debounced, registered level of f.
- fall_pulse  output  1  one-cycle strobe on an accepted 1->0 transition.
- rise_pulse  output  1  one-cycle strobe on an accepted 0->1 transition.
- fall_cnt  output  CNT_W  number of accepted falls; saturating.
- cnt_sat  output  1  high while fall_cnt equals 2^CNT_W-1.

Behaviour:
- Reset, applied on a clk edge with reset=1: s1=1, s2=1, state=HIGH, deb_cnt=0, f_clean=1, fall_pulse=0, rise_pulse=0, fall_cnt=0, cnt_sat=0. Reset dominates clr_cnt and all events. Reset mid-debounce abandons the pending change.
- Synchronizer: each edge, s1<=f and s2<=s1. The FSM looks only at s2.
- deb_cnt is sized to hold DEB_CYCLES.
- FSM states: HIGH, FALLING, LOW, RISING.
  - HIGH (f_clean=1): s2=0 -> deb_cnt<=1, next FALLING. If DEB_CYCLES=1, go straight to LOW and fire fall_pulse.
  - FALLING: s2=1 -> HIGH, deb_cnt<=0, no strobe. s2=0 and deb_cnt+1==DEB_CYCLES -> LOW, f_clean<=0, fall_pulse<=1. Otherwise deb_cnt<=deb_cnt+1.
  - LOW (f_clean=0): mirror of HIGH with s2=1 -> RISING.
  - RISING: mirror of FALLING. On acceptance: HIGH, f_clean<=1, rise_pulse<=1.
- Latency: with f held steady from sampling edge E0, f_clean changes on edge E0+DEB_CYCLES+1 (DEB_CYCLES+2 edges inclusive). The strobe is high for exactly that one following cycle.
- Glitch rejection: any excursion of s2 lasting fewer than DEB_CYCLES samples produces no f_clean change and no strobe.
- fall_pulse and rise_pulse are never high together. Neither is high for two consecutive cycles.
- Counter, evaluated on the same edge that sets fall_pulse:
  - clr_cnt=1 without a fall: fall_cnt<=0, cnt_sat<=0.
  - clr_cnt=1 together with a fall: fall_cnt<=1, cnt_sat<=0 (clear, then count).
  - fall with fall_cnt<2^CNT_W-1: increment. If the result is 2^CNT_W-1, cnt_sat<=1.
  - fall with fall_cnt==2^CNT_W-1: hold the value, no wrap-around, cnt_sat stays 1.
  - rise events do not affect the counter.
- All outputs are registered. No combinational path from f or clr_cnt to any output.

Test Plan:
- Reset/idle: reset=1 for 2 cycles, then f=1 for 20 cycles -> f_clean=1, both strobes 0, fall_cnt=0, cnt_sat=0 throughout.
- Clean fall (DEB_CYCLES=4): f 1->0 sampled at E0, held -> f_clean=0 and fall_pulse=1 both first seen after edge E5. fall_pulse=1 for exactly one cycle. fall_cnt=1.
- Glitch rejection (DEB_CYCLES=4): f=0 for 3 cycles then back to 1 -> f_clean stays 1, no strobes, fall_cnt=0. Then f=0 for 4 cycles -> fall accepted, fall_cnt=1. Then f=1 for 4 cycles -> rise_pulse once, f_clean=1.
- Saturation (CNT_W=4): 17 clean fall/rise pairs -> fall_cnt reads 15 after the 15th fall. cnt_sat=1 from that edge on. fall_cnt stays 15 after falls 16 and 17.
- Clear collision: fall_cnt=5, assert clr_cnt on the fall_pulse edge -> fall_cnt=1, cnt_sat=0. clr_cnt alone next cycle -> fall_cnt=0.
- Reset mid-debounce (DEB_CYCLES=4): f=0 for 3 cycles, reset=1 for 1 cycle with f still 0 -> f_clean=1, state HIGH, no fall_pulse. After release, f_clean falls DEB_CYCLES+2 edges later, not sooner.
